pc_sequencer: RTL and testbench

//   Next-PC controller for the MIPS core. Owns the PC register and arbitrates between sequential, branch,

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and picks the next fetch address from sequential, branch, jump, JR,
// exception and ERET sources, with a small boot/exception/handler FSM.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic        is_jump,
  input  logic        is_jr,
  input  logic [31:0] rs_data,
  input  logic        is_eret,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        in_handler
);
  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_EXC     = 2'd2;
  localparam logic [1:0] S_HANDLER = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;
  logic        flush_q, flush_d, in_handler_q, in_handler_d;
  logic        active, masked, jr_bad, take_exc;
  logic        unused;
  assign unused      = ^instr[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_valid = active;
  assign flush       = flush_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign in_handler  = in_handler_q;
  assign active      = (state_q == S_RUN) || (state_q == S_HANDLER);
  assign masked      = state_q == S_HANDLER;
  assign jr_bad      = is_jr && (rs_data[1:0] != 2'b00);
  // A misaligned JR only faults when the stall lets it issue; external requests ignore stall.
  assign take_exc    = active && !masked && (exc_req || (!stall && jr_bad));
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    in_handler_d = in_handler_q;
    flush_d      = 1'b0;
    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end else if (state_q == S_EXC) begin
      state_d = S_HANDLER;
    end else if (take_exc) begin
      epc_d        = pc_q - 32'd4;
      cause_d      = exc_req ? exc_code : 5'd4;
      pc_d         = EXC_VECTOR;
      state_d      = S_EXC;
      in_handler_d = 1'b1;
      flush_d      = 1'b1;
    end else if (!stall) begin
      flush_d = (is_eret && masked) || is_jr || is_jump || (is_branch && branch_taken);
      if (is_eret && masked) begin
        pc_d         = epc_q;
        in_handler_d = 1'b0;
        state_d      = S_RUN;
      end else if (is_jr) begin
        pc_d = rs_data;
      end else if (is_jump) begin
        pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (is_branch && branch_taken) begin
        pc_d = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      end else begin
        pc_d = pc_plus4;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= 32'd0;
      cause_q      <= 5'd0;
      flush_q      <= 1'b0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      flush_q      <= flush_d;
      in_handler_q <= in_handler_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors; expectations queued per cycle and checked by a separate monitor.
module tb_pc_sequencer;
  localparam logic [31:0] EXC = 32'h8000_0180;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        stall, is_branch, branch_taken, is_jump, is_jr, is_eret, exc_req;
  logic [31:0] instr, rs_data;
  logic [4:0]  exc_code;
  logic [31:0] pc, pc_plus4, epc;
  logic        fetch_valid, flush, in_handler;
  logic [4:0]  cause;
  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] pc;
    logic        fl, fv, ih;
    logic [31:0] epc;
    logic [4:0]  cause;
  } exp_t;
  exp_t        sb[$];
  int          cyc = 0, checks = 0, errors = 0;
  logic [31:0] e_epc = 0;
  logic [4:0]  e_cause = 0;
  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .is_branch(is_branch),
    .branch_taken(branch_taken), .is_jump(is_jump), .is_jr(is_jr), .rs_data(rs_data),
    .is_eret(is_eret), .exc_req(exc_req), .exc_code(exc_code), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .epc(epc), .cause(cause), .in_handler(in_handler)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input exp_t e);
    checks++;
    if ({pc, pc_plus4, flush, fetch_valid, in_handler, epc, cause} !==
        {e.pc, e.pc + 32'd4, e.fl, e.fv, e.ih, e.epc, e.cause}) begin
      errors++;
      $display("FAIL %s: got pc=%h pc4=%h fl=%b fv=%b ih=%b epc=%h cause=%0d; want pc=%h pc4=%h fl=%b fv=%b ih=%b epc=%h cause=%0d",
               e.name, pc, pc_plus4, flush, fetch_valid, in_handler, epc, cause,
               e.pc, e.pc + 32'd4, e.fl, e.fv, e.ih, e.epc, e.cause);
    end
  endtask
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked, now %0d", e.name, e.cyc, cyc);
      end else chk(e);
    end
  end
  task automatic clear_in();
    {stall, is_branch, branch_taken, is_jump, is_jr, is_eret, exc_req} = '0;
    instr = 0; rs_data = 0; exc_code = 0;
  endtask
  // Expect these outputs after the coming rising edge, then advance to the next falling edge.
  task automatic go(input string n, input logic [31:0] p, input logic fl, fv, ih);
    exp_t e;
    e.name = n; e.cyc = cyc + 1; e.pc = p; e.fl = fl; e.fv = fv; e.ih = ih;
    e.epc = e_epc; e.cause = e_cause;
    sb.push_back(e);
    @(negedge clk);
    clear_in();
  endtask
  task automatic reset_chk(input string n);
    exp_t e;
    e.name = n; e.cyc = cyc; e.pc = 0; e.fl = 0; e.fv = 0; e.ih = 0; e.epc = 0; e.cause = 0;
    chk(e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    clear_in();
    repeat (2) @(negedge clk);
    reset_chk("reset");
    rst_n = 1'b1;
    go("boot", 32'h0, 0, 1, 0);
    go("seq4", 32'h4, 0, 1, 0);
    go("seq8", 32'h8, 0, 1, 0);
    is_eret = 1;
    go("eret_nop_run", 32'hC, 0, 1, 0);
    is_jr = 1; rs_data = 32'h8FFF_FFFC;
    go("jr", 32'h8FFF_FFFC, 1, 1, 0);
    is_jump = 1; instr = 32'h00D4_CC19;
    go("jump", 32'h9353_3064, 1, 1, 0);
    go("after_jump", 32'h9353_3068, 0, 1, 0);
    is_jr = 1; rs_data = 32'h100;
    go("jr100", 32'h100, 1, 1, 0);
    is_branch = 1; branch_taken = 1; instr = 32'h0000_0003;
    go("br_fwd", 32'h110, 1, 1, 0);
    is_jr = 1; rs_data = 32'h100;
    go("jr100b", 32'h100, 1, 1, 0);
    is_branch = 1; branch_taken = 1; instr = 32'h0000_FFFF;
    go("br_back", 32'h100, 1, 1, 0);
    is_branch = 1; instr = 32'h0000_FFFF;
    go("br_not_taken", 32'h104, 0, 1, 0);
    stall = 1; is_jump = 1; instr = 32'h0000_1234;
    go("stall_drop", 32'h104, 0, 1, 0);
    is_jr = 1; rs_data = 32'hFFFF_FFFC;
    go("jr_top", 32'hFFFF_FFFC, 1, 1, 0);
    go("wrap", 32'h0, 0, 1, 0);
    is_jr = 1; is_jump = 1; rs_data = 32'h200; instr = 32'h0000_0040;
    go("jr_over_jump", 32'h200, 1, 1, 0);
    is_jr = 1; rs_data = 32'h0000_2002; e_epc = 32'h1FC; e_cause = 5'd4;
    go("jr_misalign", EXC, 1, 0, 1);
    exc_req = 1; exc_code = 5'd7;
    go("exc_in_sexc", EXC, 0, 1, 1);
    exc_req = 1; exc_code = 5'd12;
    go("exc_masked", EXC + 32'd4, 0, 1, 1);
    is_eret = 1;
    go("eret", 32'h1FC, 1, 1, 0);
    stall = 1; is_jump = 1; exc_req = 1; exc_code = 5'd12; e_epc = 32'h1F8; e_cause = 5'd12;
    go("exc_stall", EXC, 1, 0, 1);
    go("handler2", EXC, 0, 1, 1);
    go("handler_seq", EXC + 32'd4, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1 reset_chk("async_reset");
    e_epc = 0; e_cause = 0;
    @(negedge clk);
    rst_n = 1'b1;
    go("reboot", 32'h0, 0, 1, 0);
    go("reboot_seq", 32'h4, 0, 1, 0);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
